// File: rtl/nv_ram_fifo_ctrl_32x544.sv
// nv_ram_fifo_ctrl_32x544
// Turns an external 32 x 544 1R1W RAM with a registered read port into a
// valid/ready FIFO. It owns the RAM write/read pointers and occupancy. A
// 2-entry skid buffer behind the RAM read port keeps one pop per cycle going
// while the consumer applies backpressure.
//
// Optional feature macro: NV_RAM_FIFO_CTRL_HWM_EN
//   When defined, the block adds input hwm_clr and output fifo_hwm. fifo_hwm
//   holds the highest fifo_count seen since rst or the last hwm_clr.
//
// Handshake: a beat moves on a rising clk edge exactly when valid and ready
// are both high in that cycle. A valid beat is held with its payload stable
// until it is accepted, and ready never depends combinationally on valid.
module nv_ram_fifo_ctrl_32x544 #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 544
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   fifo_count,
`ifdef NV_RAM_FIFO_CTRL_HWM_EN
  input  logic          hwm_clr,
  output logic [AW:0]   fifo_hwm,
`endif
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd
);

  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

  // RAM-side state
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;       // entries whose RAM write finished at an earlier edge
  logic          inflight;      // a read was issued last cycle; ram_dout is valid now
  logic          wr_rdy_q;
  logic [AW:0]   fifo_count_q;

  // Skid buffer state
  logic [DW-1:0] skid_mem [2];
  logic          skid_rp;
  logic          skid_wp;
  logic [1:0]    skid_cnt;

  // Per-cycle events and next-state values
  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    skid_after;    // skid occupancy after this cycle's capture and pop
  logic [AW:0]   ram_cnt_next;
  logic [AW:0]   fifo_count_next;

  assign push    = wr_pvld & wr_prdy;
  assign rd_pvld = (skid_cnt != 2'd0);
  assign pop     = rd_pvld & rd_prdy;
  assign rd_pd   = skid_mem[skid_rp];
  assign wr_prdy = wr_rdy_q;

  // A read is only issued when its data is sure to have a skid slot on arrival.
  assign skid_after = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (ram_cnt != '0) && (skid_after < 3'd2);

  assign ram_we = push;
  assign ram_wa = wptr;
  assign ram_di = wr_pd;
  assign ram_re = issue;
  assign ram_ra = rptr;

  assign fifo_count        = fifo_count_q;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  // Next RAM occupancy: a push only becomes readable after its edge has passed.
  always_comb begin
    ram_cnt_next = ram_cnt;
    case ({push, issue})
      2'b10:   ram_cnt_next = ram_cnt + 1'b1;
      2'b01:   ram_cnt_next = ram_cnt - 1'b1;
      default: ram_cnt_next = ram_cnt;
    endcase
  end

  // Next total occupancy across RAM, the in-flight read and the skid buffer.
  always_comb begin
    fifo_count_next = ram_cnt_next
                    + {{AW{1'b0}}, issue}
                    + {{(AW-1){1'b0}}, skid_after[1:0]};
  end

  // Pointers, RAM occupancy, in-flight flag and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      ram_cnt      <= '0;
      inflight     <= 1'b0;
      wr_rdy_q     <= 1'b1;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (issue) begin
        rptr <= rptr + 1'b1;
      end
      ram_cnt      <= ram_cnt_next;
      inflight     <= issue;
      wr_rdy_q     <= (ram_cnt_next < DEPTH_V);
      fifo_count_q <= fifo_count_next;
    end
  end

  // Skid buffer control: capture returning RAM data at the tail, pop from the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_rp  <= 1'b0;
      skid_wp  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (inflight) begin
        skid_wp <= ~skid_wp;
      end
      if (pop) begin
        skid_rp <= ~skid_rp;
      end
      skid_cnt <= skid_after[1:0];
    end
  end

  // Skid payload storage; contents are meaningless while the entry is empty.
  always_ff @(posedge clk) begin
    if (inflight) begin
      skid_mem[skid_wp] <= ram_dout;
    end
  end

`ifdef NV_RAM_FIFO_CTRL_HWM_EN
  logic [AW:0] hwm_q;

  assign fifo_hwm = hwm_q;

  // High-water mark of fifo_count; hwm_clr restarts it from the current level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (hwm_clr) begin
      hwm_q <= fifo_count_q;
    end else if (fifo_count_q > hwm_q) begin
      hwm_q <= fifo_count_q;
    end
  end
`endif

`ifndef SYNTHESIS
  // The issue rule and the registered wr_prdy make these states unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (skid_cnt <= 2'd2) && (ram_cnt <= DEPTH_V));
`endif

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_32x544.sv
// tb_nv_ram_fifo_ctrl_32x544
// Directed bench for nv_ram_fifo_ctrl_32x544 with a behavioural RAM model.
// A negedge monitor keeps an expected-data queue and checks ordering,
// occupancy, RAM addressing, outstanding reads and payload stability.
// Define NV_RAM_FIFO_CTRL_HWM_EN to also exercise the high-water mark.
module tb_nv_ram_fifo_ctrl_32x544;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 544;

  logic          clk;
  logic          rst;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   fifo_count;
  logic [31:0]   pwrbus_ram_pd;
  logic [31:0]   ram_pwrbus_ram_pd;
`ifdef NV_RAM_FIFO_CTRL_HWM_EN
  logic          hwm_clr;
  logic [AW:0]   fifo_hwm;
`endif

  int n_checks;
  int n_fail;

  nv_ram_fifo_ctrl_32x544 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .ram_we            (ram_we),
    .ram_wa            (ram_wa),
    .ram_di            (ram_di),
    .ram_re            (ram_re),
    .ram_ra            (ram_ra),
    .ram_dout          (ram_dout),
    .fifo_count        (fifo_count),
`ifdef NV_RAM_FIFO_CTRL_HWM_EN
    .hwm_clr           (hwm_clr),
    .fifo_hwm          (fifo_hwm),
`endif
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
  );

  // ---------------- clock and reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model: registered read port ----------------
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= ram_mem[ram_ra];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep8(input logic [7:0] b);
    return {68{b}};
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = i;
    return {17{w}};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] exp_wa;
  logic [AW-1:0] exp_ra;
  int            outst;
  logic          hold_v;
  logic [DW-1:0] hold_pd;
  logic          tb_push;
  logic          tb_pop;

  assign tb_push = wr_pvld & wr_prdy;
  assign tb_pop  = rd_pvld & rd_prdy;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_wa = '0;
      exp_ra = '0;
      outst  = 0;
      hold_v = 1'b0;
    end else begin
      check("fifo_count", DW'(fifo_count), DW'(exp_q.size()));
      if (hold_v && rd_pvld) check("rd_pd_stable", rd_pd, hold_pd);
      if (ram_we) begin
        check("ram_wa", DW'(ram_wa), DW'(exp_wa));
        exp_wa = exp_wa + 1'b1;
      end
      if (ram_re) begin
        check("ram_ra", DW'(ram_ra), DW'(exp_ra));
        exp_ra = exp_ra + 1'b1;
      end
      check("outstanding_le2", DW'((outst + int'(ram_re) - int'(tb_pop)) <= 2), DW'(1'b1));
      outst = outst + int'(ram_re) - int'(tb_pop);
      if (tb_pop) begin
        if (exp_q.size() == 0) check("pop_when_empty", DW'(1'b1), DW'(1'b0));
        else check("rd_pd", rd_pd, exp_q.pop_front());
      end
      if (tb_push) exp_q.push_back(wr_pd);
      hold_v  = rd_pvld & ~rd_prdy;
      hold_pd = rd_pd;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int acc;
    int cyc;
    int pops;
    int bubbles;

    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    wr_pvld       = 1'b0;
    wr_pd         = '0;
    rd_prdy       = 1'b0;
    pwrbus_ram_pd = 32'hDEAD_BEEF;
`ifdef NV_RAM_FIFO_CTRL_HWM_EN
    hwm_clr       = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_wr_prdy", DW'(wr_prdy), DW'(1'b1));
    check("rst_rd_pvld", DW'(rd_pvld), DW'(1'b0));
    check("rst_ram_we", DW'(ram_we), DW'(1'b0));
    check("rst_ram_re", DW'(ram_re), DW'(1'b0));
    check("rst_fifo_count", DW'(fifo_count), DW'(0));
    check("pwrbus_pass", DW'(ram_pwrbus_ram_pd), DW'(32'hDEAD_BEEF));
    pwrbus_ram_pd = 32'h0000_1234;
    #1;
    check("pwrbus_pass2", DW'(ram_pwrbus_ram_pd), DW'(32'h0000_1234));

    // single entry latency: cycle 0 push
    rst     = 1'b0;
    wr_pvld = 1'b1;
    wr_pd   = rep8(8'hA5);
    rd_prdy = 1'b1;
    #1;
    check("c0_ram_we", DW'(ram_we), DW'(1'b1));
    check("c0_ram_di", ram_di, rep8(8'hA5));
    next_cycle();  // cycle 1
    wr_pvld = 1'b0;
    check("c1_ram_re", DW'(ram_re), DW'(1'b1));
    check("c1_rd_pvld", DW'(rd_pvld), DW'(1'b0));
    next_cycle();  // cycle 2
    check("c2_ram_re", DW'(ram_re), DW'(1'b0));
    check("c2_rd_pvld", DW'(rd_pvld), DW'(1'b0));
    check("c2_fifo_count", DW'(fifo_count), DW'(1));
    next_cycle();  // cycle 3
    check("c3_rd_pvld", DW'(rd_pvld), DW'(1'b1));
    check("c3_rd_pd", rd_pd, rep8(8'hA5));
    next_cycle();  // cycle 4
    check("c4_rd_pvld", DW'(rd_pvld), DW'(1'b0));
    check("c4_fifo_count", DW'(fifo_count), DW'(0));

    // fill with consumer stalled: 32 in RAM plus 2 in skid
    rd_prdy = 1'b0;
    acc     = 0;
    for (int i = 0; i < 40; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = pat(acc);
      if (wr_prdy) acc++;
      next_cycle();
    end
    wr_pvld = 1'b0;
    check("fill_accepted", DW'(acc), DW'(34));
    check("fill_wr_prdy", DW'(wr_prdy), DW'(1'b0));
    check("fill_fifo_count", DW'(fifo_count), DW'(34));
    rd_prdy = 1'b1;
    pops    = 0;
    for (int i = 0; i < 34; i++) begin
      if (rd_pvld) pops++;
      next_cycle();
    end
    check("drain_back_to_back", DW'(pops), DW'(34));
    check("drain_empty", DW'(fifo_count), DW'(0));
    check("drain_wr_prdy", DW'(wr_prdy), DW'(1'b1));

    // streaming: 100 beats, output every cycle after the 3-cycle fill
    pops    = 0;
    bubbles = 0;
    for (int c = 0; c < 103; c++) begin
      wr_pvld = (c < 100);
      wr_pd   = pat(1000 + c);
      if (rd_pvld) pops++;
      else if (c >= 3) bubbles++;
      next_cycle();
    end
    wr_pvld = 1'b0;
    check("stream_pops", DW'(pops), DW'(100));
    check("stream_bubbles", DW'(bubbles), DW'(0));

    // random backpressure over 500 accepted beats
    acc = 0;
    cyc = 0;
    while (acc < 500 && cyc < 5000) begin
      rd_prdy = 1'($urandom_range(0, 1));
      wr_pvld = 1'b1;
      wr_pd   = pat(5000 + acc);
      if (wr_prdy) acc++;
      next_cycle();
      cyc++;
    end
    wr_pvld = 1'b0;
    check("rand_accepted", DW'(acc), DW'(500));
    rd_prdy = 1'b1;
    cyc     = 0;
    while (fifo_count != 0 && cyc < 200) begin
      next_cycle();
      cyc++;
    end
    check("rand_drain", DW'(fifo_count), DW'(0));
    check("rand_queue_empty", DW'(exp_q.size()), DW'(0));

    // reset mid-stream with 10 held and a read in flight
    rd_prdy = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = pat(9000 + i);
      next_cycle();
    end
    wr_pvld = 1'b0;
    repeat (3) next_cycle();
    check("mid_held11", DW'(fifo_count), DW'(11));
    rd_prdy = 1'b1;
    #1;
    check("mid_issue", DW'(ram_re), DW'(1'b1));
    next_cycle();
    rd_prdy = 1'b0;
    check("mid_held10", DW'(fifo_count), DW'(10));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("mid_rst_rd_pvld", DW'(rd_pvld), DW'(1'b0));
    check("mid_rst_count", DW'(fifo_count), DW'(0));
    check("mid_rst_wr_prdy", DW'(wr_prdy), DW'(1'b1));
    wr_pvld = 1'b1;
    wr_pd   = rep8(8'h5A);
    next_cycle();
    wr_pvld = 1'b0;
    for (int k = 0; k < 10 && !rd_pvld; k++) next_cycle();
    check("mid_first_valid", DW'(rd_pvld), DW'(1'b1));
    check("mid_first_data", rd_pd, rep8(8'h5A));
    rd_prdy = 1'b1;
    next_cycle();
    check("mid_after_pop", DW'(rd_pvld), DW'(1'b0));

`ifdef NV_RAM_FIFO_CTRL_HWM_EN
    // high-water mark: 20 deep, then clear while empty
    rd_prdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = pat(7000 + i);
      next_cycle();
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    cyc     = 0;
    while (fifo_count != 0 && cyc < 100) begin
      next_cycle();
      cyc++;
    end
    next_cycle();
    check("hwm_drained", DW'(fifo_count), DW'(0));
    check("hwm_peak", DW'(fifo_hwm), DW'(20));
    hwm_clr = 1'b1;
    next_cycle();
    hwm_clr = 1'b0;
    check("hwm_clear", DW'(fifo_hwm), DW'(0));
`endif

    repeat (3) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_ram_fifo_ctrl_32x544.md
Name: nv_ram_fifo_ctrl_32x544

Overview:
FIFO controller that turns an external 32-entry x 544-bit 1R1W RAM into a valid/ready FIFO. The RAM registers its read address on re, so data appears one cycle after issue. The block owns the RAM write/read pointers and occupancy, and adds a 2-entry output skid buffer so reads sustain one pop per cycle under backpressure. It sits between a producer and a consumer pipe stage, and passes the RAM power-down bus through.

Parameters:
DEPTH, 32, RAM entries (power of two).
AW, 5, RAM address width, log2(DEPTH).
DW, 544, payload width.

Ports:
clk  in  1  core clock; all state on posedge.
rst  in  1  synchronous, active-high reset.
wr_pvld  in  1  producer valid.
wr_prdy  out  1  producer ready.
wr_pd  in  DW  producer payload.
rd_pvld  out  1  consumer valid.
rd_prdy  in  1  consumer ready.
rd_pd  out  DW  consumer payload.
ram_we  out  1  RAM write enable.
ram_wa  out  AW  RAM write address.
ram_di  out  DW  RAM write data (equals wr_pd).
ram_re  out  1  RAM read enable (RAM latches ra).
ram_ra  out  AW  RAM read address.
ram_dout  in  DW  RAM read data, valid the cycle after ram_re.
fifo_count  out  AW+1  total entries held: RAM + in-flight + skid, range 0..DEPTH+2.
pwrbus_ram_pd  in  32  power-down bus from the top level.
ram_pwrbus_ram_pd  out  32  equals pwrbus_ram_pd, combinational passthrough.

Behaviour:
- Reset values: wr_prdy=1, rd_pvld=0, ram_we=0, ram_re=0, fifo_count=0. Write and read pointers, ram_cnt, inflight flag and skid state all clear. rd_pd is don't-care while rd_pvld=0.
- Reset mid-operation: the in-flight read and all skid entries are discarded. RAM contents are untouched but treated as empty.
- Write: push = wr_pvld & wr_prdy. wr_prdy = (ram_cnt < DEPTH), a registered compare. ram_we=push, ram_wa=wptr, ram_di=wr_pd. wptr increments modulo DEPTH on push.
- Read issue: ram_re=1 when ram_cnt>0 and (skid_cnt + inflight - pop) < 2, where pop = rd_pvld & rd_prdy. ram_ra=rptr. rptr increments modulo DEPTH on issue. inflight is set next cycle iff issued.
- ram_cnt counts only entries whose write completed at an earlier edge, so a read never targets the address being written in the same cycle. ram_cnt_next = ram_cnt + push - issue; simultaneous push and issue leaves it unchanged.
- Capture: when inflight=1, ram_dout is written into the skid tail that same cycle.
- Skid: 2-entry FIFO. rd_pvld = (skid_cnt>0), rd_pd = skid head. rd_pd must stay stable while rd_pvld & !rd_prdy.
- Latency: write accepted in cycle 0 -> issue in cycle 1 -> capture in cycle 2 -> rd_pvld in cycle 3. There is no write-to-read bypass.
- Throughput: one push and one pop per cycle sustained. Capacity is DEPTH+2 entries; wr_prdy only tracks RAM space.
- fifo_count = ram_cnt + inflight + skid_cnt, registered.
- Wrap-around: pointers roll from 31 to 0 with no bubble.
- Overflow and underflow cannot occur by construction. A simulation assertion fires on skid_cnt>2 or ram_cnt>DEPTH.

Optional Feature:
NV_RAM_FIFO_CTRL_HWM_EN
- Defined: adds input hwm_clr (1) and output fifo_hwm (AW+1). fifo_hwm holds the maximum fifo_count seen since rst or hwm_clr, updating each cycle. hwm_clr=1 loads the current fifo_count. Reset value 0.
- Undefined: neither port exists and no high-water-mark logic is built.

Test Plan:
- Single entry: rst, then push 0xA5 (replicated) in cycle 0 with rd_prdy=1 -> ram_re in cycle 1, rd_pvld=1 with rd_pd=0xA5.. in cycle 3, fifo_count back to 0 in cycle 4.
- Fill: rd_prdy=0, push 40 beats of incrementing data -> 34 accepted (32 RAM + 2 skid), wr_prdy=0 at fifo_count=34. Then rd_prdy=1 -> data 0..33 in order, one per cycle.
- Streaming: wr_pvld=1 and rd_prdy=1 continuously for 100 beats -> after a 3-cycle fill, one pop every cycle with no bubble; pointers wrap 31->0 three times.
- Random backpressure: rd_prdy toggles at 50% over 500 beats -> ordered and lossless; rd_pd stable while stalled; ram_re never leaves more than 2 entries outstanding in skid plus in-flight.
- Reset mid-stream: assert rst with 10 entries held and a read in flight -> next cycle rd_pvld=0, fifo_count=0, wr_prdy=1. A subsequent push of 0x5A produces 0x5A as the first output.
- With NV_RAM_FIFO_CTRL_HWM_EN: push 20 then drain -> fifo_hwm=20. Pulse hwm_clr while empty -> fifo_hwm=0.
